cm_out_collect: RTL and testbench

Bit-serial result collector for the near-memory-compute macro array: the return path of the bit-serial activation feeder. It receives one signed partial sum per lane per compute cycle, LSB plane first, and shift-accumulates COMPUTE_CYCLE planes into a full-precision dot product. Completed results go to the output buffer over a valid/ready handshake, tagged with the macro row/column address they belong to.

---
 rtl/cim_pkg.sv | 17 +
 rtl/cm_out_collect_if.sv | 27 ++
 rtl/cm_out_collect_lane_acc.sv | 55 +++++
 rtl/cm_out_collect.sv | 96 +++++++++
 tb/tb_cm_out_collect.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cim_pkg.sv
// Shared near-memory-compute parameters, used by both the activation feeder and the result collector
// so both ends agree on bit-plane count and order.
package cim_pkg;

  localparam int COMPUTE_CYCLE     = 8;
  localparam int PSUM_WIDTH        = 8;
  localparam int LANES             = 4;
  localparam int MACRO_ROW         = 32;
  localparam int MACRO_COLUMN      = 4;
  localparam int MACROS_ADDR_WIDTH = 8;

  // Widest shifted partial sum plus one guard bit for the accumulation and negation.
  function automatic int acc_width(input int psum_w, input int planes);
    return psum_w + planes + 1;
  endfunction

endpackage

// File: rtl/cm_out_collect_if.sv
// Partial-sum input beats and accumulated result output of the bit-serial collector.
interface cm_out_collect_if #(
  parameter int LANES      = cim_pkg::LANES,
  parameter int PSUM_WIDTH = cim_pkg::PSUM_WIDTH,
  parameter int ACC_WIDTH  = cim_pkg::acc_width(cim_pkg::PSUM_WIDTH, cim_pkg::COMPUTE_CYCLE),
  parameter int ADDR_WIDTH = cim_pkg::MACROS_ADDR_WIDTH
);

  logic [LANES*PSUM_WIDTH-1:0] nmc_cmOut;
  logic                        nmc_cmOut_vld;
  logic                        nmc_cmOut_rdy;
  logic [LANES*ACC_WIDTH-1:0]  data_out;
  logic [ADDR_WIDTH-1:0]       data_out_addr;
  logic                        data_out_vld;
  logic                        data_out_rdy;

  modport slave (
    input  nmc_cmOut, nmc_cmOut_vld, data_out_rdy,
    output nmc_cmOut_rdy, data_out, data_out_addr, data_out_vld
  );

  modport master (
    output nmc_cmOut, nmc_cmOut_vld, data_out_rdy,
    input  nmc_cmOut_rdy, data_out, data_out_addr, data_out_vld
  );

endinterface

// File: rtl/cm_out_collect_lane_acc.sv
// One lane of the collector: sign-extend, shift by bit plane, negate the MSB plane for signed
// activations, and accumulate. o_sum is the running total including the current beat.
module cm_out_lane_acc
  import cim_pkg::*;
#(
  parameter int PSUM_WIDTH    = cim_pkg::PSUM_WIDTH,
  parameter int COMPUTE_CYCLE = cim_pkg::COMPUTE_CYCLE,
  parameter int ACC_WIDTH     = acc_width(PSUM_WIDTH, COMPUTE_CYCLE),
  parameter int CNT_WIDTH     = $clog2(COMPUTE_CYCLE),
  parameter int SIGNED_IN     = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [PSUM_WIDTH-1:0]       i_psum,
  input  logic [CNT_WIDTH-1:0]        i_cnt,
  input  logic                        i_beat,
  output logic signed [ACC_WIDTH-1:0] o_sum
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(COMPUTE_CYCLE - 1);

  logic signed [ACC_WIDTH-1:0] r_acc;
  logic signed [ACC_WIDTH-1:0] w_ext;
  logic signed [ACC_WIDTH-1:0] w_shift;
  logic signed [ACC_WIDTH-1:0] w_term;
  logic signed [ACC_WIDTH-1:0] w_sum;

  // Plane term and running sum; plane 0 starts fresh so no stale carry-in survives a group.
  always_comb begin
    w_ext   = {{(ACC_WIDTH - PSUM_WIDTH){i_psum[PSUM_WIDTH-1]}}, i_psum};
    w_shift = w_ext <<< i_cnt;
    if ((SIGNED_IN != 0) && (i_cnt == CNT_LAST)) begin
      w_term = -w_shift;
    end else begin
      w_term = w_shift;
    end
    if (i_cnt == {CNT_WIDTH{1'b0}}) begin
      w_sum = w_term;
    end else begin
      w_sum = r_acc + w_term;
    end
  end

  // Accumulator register, updated on every accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= {ACC_WIDTH{1'b0}};
    end else if (i_beat) begin
      r_acc <= w_sum;
    end
  end

  assign o_sum = w_sum;

endmodule

// File: rtl/cm_out_collect.sv
// Bit-serial result collector: accumulates COMPUTE_CYCLE LSB-first partial-sum planes per lane and
// hands each completed dot product downstream through a one-entry buffer tagged with its macro address.
module cm_out_collect
  import cim_pkg::*;
#(
  parameter int COMPUTE_CYCLE     = cim_pkg::COMPUTE_CYCLE,
  parameter int LANES             = cim_pkg::LANES,
  parameter int PSUM_WIDTH        = cim_pkg::PSUM_WIDTH,
  parameter int SIGNED_IN         = 1,
  parameter int MACROS_ADDR_WIDTH = cim_pkg::MACROS_ADDR_WIDTH,
  parameter int MACRO_ROW         = cim_pkg::MACRO_ROW,
  parameter int MACRO_COLUMN      = cim_pkg::MACRO_COLUMN
) (
  input  logic             clk,
  input  logic             rst_n,
  cm_out_collect_if.slave  bus
);

  localparam int ACC_WIDTH = acc_width(PSUM_WIDTH, COMPUTE_CYCLE);
  localparam int CNT_WIDTH = $clog2(COMPUTE_CYCLE);
  localparam logic [CNT_WIDTH-1:0]         CNT_LAST  = CNT_WIDTH'(COMPUTE_CYCLE - 1);
  localparam logic [MACROS_ADDR_WIDTH-1:0] ADDR_LAST = MACROS_ADDR_WIDTH'(MACRO_ROW * MACRO_COLUMN - 1);

  logic [CNT_WIDTH-1:0]         r_cnt;
  logic                         r_vld;
  logic [LANES*ACC_WIDTH-1:0]   r_data;
  logic [MACROS_ADDR_WIDTH-1:0] r_addr;
  logic [LANES*ACC_WIDTH-1:0]   w_sums;
  logic                         w_last;
  logic                         w_rdy;
  logic                         w_beat;
  logic                         w_out_hs;

  // Only the final plane can stall, and only when the buffer is full and not draining.
  always_comb begin
    w_last   = (r_cnt == CNT_LAST);
    w_rdy    = ~w_last | ~r_vld | bus.data_out_rdy;
    w_beat   = bus.nmc_cmOut_vld & w_rdy;
    w_out_hs = r_vld & bus.data_out_rdy;
  end

  // Bit-plane counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {CNT_WIDTH{1'b0}};
    end else if (w_beat) begin
      r_cnt <= w_last ? {CNT_WIDTH{1'b0}} : r_cnt + CNT_WIDTH'(1);
    end
  end

  // One-entry output buffer; a final beat in the drain cycle reloads it without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= 1'b0;
      r_data <= {(LANES*ACC_WIDTH){1'b0}};
    end else if (w_beat && w_last) begin
      r_vld  <= 1'b1;
      r_data <= w_sums;
    end else if (w_out_hs) begin
      r_vld  <= 1'b0;
      r_data <= {(LANES*ACC_WIDTH){1'b0}};
    end
  end

  // Result address advances once per delivered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= {MACROS_ADDR_WIDTH{1'b0}};
    end else if (w_out_hs) begin
      r_addr <= (r_addr == ADDR_LAST) ? {MACROS_ADDR_WIDTH{1'b0}} : r_addr + MACROS_ADDR_WIDTH'(1);
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    cm_out_lane_acc #(
      .PSUM_WIDTH    (PSUM_WIDTH),
      .COMPUTE_CYCLE (COMPUTE_CYCLE),
      .ACC_WIDTH     (ACC_WIDTH),
      .CNT_WIDTH     (CNT_WIDTH),
      .SIGNED_IN     (SIGNED_IN)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_psum (bus.nmc_cmOut[gi*PSUM_WIDTH +: PSUM_WIDTH]),
      .i_cnt  (r_cnt),
      .i_beat (w_beat),
      .o_sum  (w_sums[gi*ACC_WIDTH +: ACC_WIDTH])
    );
  end

  assign bus.nmc_cmOut_rdy = w_rdy;
  assign bus.data_out      = r_data;
  assign bus.data_out_addr = r_addr;
  assign bus.data_out_vld  = r_vld;

endmodule

// File: tb/tb_cm_out_collect.sv
// Bench for cm_out_collect: an unsigned and a signed instance share one stimulus stream and are
// compared against a plane-list dot-product model plus the fixed values of the directed scenarios.
module tb_cm_out_collect;
  import cim_pkg::*;

  localparam int CC    = COMPUTE_CYCLE;
  localparam int NL    = LANES;
  localparam int PW    = PSUM_WIDTH;
  localparam int ACC   = acc_width(PSUM_WIDTH, COMPUTE_CYCLE);
  localparam int AW    = MACROS_ADDR_WIDTH;
  localparam int NADDR = MACRO_ROW * MACRO_COLUMN;

  typedef int lane_arr_t [NL];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cm_out_collect_if #(.LANES(NL), .PSUM_WIDTH(PW), .ACC_WIDTH(ACC), .ADDR_WIDTH(AW)) bus_u ();
  cm_out_collect_if #(.LANES(NL), .PSUM_WIDTH(PW), .ACC_WIDTH(ACC), .ADDR_WIDTH(AW)) bus_s ();

  cm_out_collect #(.COMPUTE_CYCLE(CC), .LANES(NL), .PSUM_WIDTH(PW), .SIGNED_IN(0),
                   .MACROS_ADDR_WIDTH(AW), .MACRO_ROW(MACRO_ROW), .MACRO_COLUMN(MACRO_COLUMN))
    u_dut_u (.clk(clk), .rst_n(rst_n), .bus(bus_u));
  cm_out_collect #(.COMPUTE_CYCLE(CC), .LANES(NL), .PSUM_WIDTH(PW), .SIGNED_IN(1),
                   .MACROS_ADDR_WIDTH(AW), .MACRO_ROW(MACRO_ROW), .MACRO_COLUMN(MACRO_COLUMN))
    u_dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

  // Reference model: list of accepted planes for the open group, plus the held result.
  lane_arr_t q_planes[$];
  bit        m_vld;
  int        m_u[NL];
  int        m_s[NL];
  int        m_addr;
  bit        exp_rdy, got_rdy_u, got_rdy_s;
  int        n_checks = 0;
  int        n_errors = 0;

  function automatic logic [NL*PW-1:0] pack(input lane_arr_t p);
    logic [NL*PW-1:0] v;
    v = '0;
    for (int l = 0; l < NL; l++) v[l*PW +: PW] = PW'(p[l]);
    return v;
  endfunction

  function automatic int lane_u(input int l);
    logic signed [ACC-1:0] v;
    v = bus_u.data_out[l*ACC +: ACC];
    return int'(v);
  endfunction

  function automatic int lane_s(input int l);
    logic signed [ACC-1:0] v;
    v = bus_s.data_out[l*ACC +: ACC];
    return int'(v);
  endfunction

  function automatic int rnd_psum();
    return int'($urandom_range(0, (1 << PW) - 1)) - (1 << (PW - 1));
  endfunction

  task automatic model_reset();
    q_planes.delete();
    m_vld  = 1'b0;
    m_addr = 0;
    for (int l = 0; l < NL; l++) begin
      m_u[l] = 0;
      m_s[l] = 0;
    end
  endtask

  // Dot product straight from the plane list: sum psum_k * 2^k, MSB plane weighted -2^k when signed.
  task automatic model_step(input bit acc, input bit drdy, input lane_arr_t p);
    int su, ss, w;
    if (m_vld && drdy) begin
      m_vld  = 1'b0;
      m_addr = (m_addr + 1) % NADDR;
    end
    if (acc) begin
      q_planes.push_back(p);
      if (q_planes.size() == CC) begin
        for (int l = 0; l < NL; l++) begin
          su = 0;
          ss = 0;
          for (int k = 0; k < CC; k++) begin
            w  = q_planes[k][l] * (1 << k);
            su = su + w;
            ss = (k == CC - 1) ? ss - w : ss + w;
          end
          m_u[l] = su;
          m_s[l] = ss;
        end
        m_vld = 1'b1;
        q_planes.delete();
      end
    end
  endtask

  task automatic drive_cycle(input bit vld, input lane_arr_t p, input bit drdy);
    @(negedge clk);
    bus_u.nmc_cmOut = pack(p);   bus_s.nmc_cmOut = pack(p);
    bus_u.nmc_cmOut_vld = vld;   bus_s.nmc_cmOut_vld = vld;
    bus_u.data_out_rdy = drdy;   bus_s.data_out_rdy = drdy;
    #3;
    exp_rdy   = (q_planes.size() != CC - 1) || !m_vld || drdy;
    got_rdy_u = bus_u.nmc_cmOut_rdy;
    got_rdy_s = bus_s.nmc_cmOut_rdy;
    @(posedge clk);
    #1;
    model_step(vld && exp_rdy, drdy, p);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus_u.nmc_cmOut_vld = 1'b0;  bus_s.nmc_cmOut_vld = 1'b0;
    bus_u.data_out_rdy = 1'b0;   bus_s.data_out_rdy = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    bus_u.nmc_cmOut = '0;        bus_s.nmc_cmOut = '0;
    bus_u.nmc_cmOut_vld = 1'b0;  bus_s.nmc_cmOut_vld = 1'b0;
    bus_u.data_out_rdy = 1'b0;   bus_s.data_out_rdy = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (bus_u.data_out_vld !== 1'b0 || bus_s.data_out_vld !== 1'b0) begin
      n_errors++; $display("FAIL reset_vld got %b/%b want 0", bus_u.data_out_vld, bus_s.data_out_vld);
    end
    n_checks++;
    if (bus_u.data_out_addr !== '0 || bus_s.data_out_addr !== '0) begin
      n_errors++; $display("FAIL reset_addr got %0d/%0d want 0", bus_u.data_out_addr, bus_s.data_out_addr);
    end
    n_checks++;
    if (bus_u.data_out !== '0 || bus_s.data_out !== '0) begin
      n_errors++; $display("FAIL reset_data got %h/%h want 0", bus_u.data_out, bus_s.data_out);
    end
    n_checks++;
    if (bus_u.nmc_cmOut_rdy !== 1'b1 || bus_s.nmc_cmOut_rdy !== 1'b1) begin
      n_errors++; $display("FAIL reset_rdy got %b/%b want 1", bus_u.nmc_cmOut_rdy, bus_s.nmc_cmOut_rdy);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned_ones();
    lane_arr_t p;
    for (int l = 0; l < NL; l++) p[l] = 1;
    for (int k = 0; k < CC; k++) begin
      drive_cycle(1'b1, p, 1'b1);
      n_checks++;
      if (bus_u.data_out_vld !== (k == CC - 1)) begin
        n_errors++; $display("FAIL ones_vld beat%0d got %b want %b", k, bus_u.data_out_vld, (k == CC - 1));
      end
    end
    for (int l = 0; l < NL; l++) begin
      n_checks++;
      if (lane_u(l) !== 255 || lane_s(l) !== -1) begin
        n_errors++; $display("FAIL ones_lane%0d got %0d/%0d want 255/-1", l, lane_u(l), lane_s(l));
      end
    end
    n_checks++;
    if (bus_u.data_out_addr !== AW'(0)) begin
      n_errors++; $display("FAIL ones_addr got %0d want 0", bus_u.data_out_addr);
    end
  endtask

  task automatic test_signed_planes();
    lane_arr_t p;
    for (int k = 0; k < CC; k++) begin
      for (int l = 0; l < NL; l++) p[l] = (k == 2) ? -3 : 0;
      drive_cycle(1'b1, p, 1'b1);
    end
    for (int l = 0; l < NL; l++) begin
      n_checks++;
      if (lane_s(l) !== -12 || lane_u(l) !== -12) begin
        n_errors++; $display("FAIL plane2_lane%0d got %0d/%0d want -12/-12", l, lane_s(l), lane_u(l));
      end
    end
    for (int k = 0; k < CC; k++) begin
      for (int l = 0; l < NL; l++) p[l] = (k == CC - 1) ? 5 : 0;
      drive_cycle(1'b1, p, 1'b1);
    end
    for (int l = 0; l < NL; l++) begin
      n_checks++;
      if (lane_s(l) !== -640 || lane_u(l) !== 640) begin
        n_errors++; $display("FAIL plane7_lane%0d got %0d/%0d want -640/640", l, lane_s(l), lane_u(l));
      end
    end
    n_checks++;
    if (int'(bus_s.data_out_addr) !== m_addr || bus_s.data_out_vld !== 1'b1) begin
      n_errors++; $display("FAIL plane7_addr got %0d vld %b want %0d vld 1", bus_s.data_out_addr, bus_s.data_out_vld, m_addr);
    end
  endtask

  task automatic test_back_to_back();
    lane_arr_t p;
    lane_arr_t pb[CC];
    int a_u[NL];
    int a_addr;
    for (int l = 0; l < NL; l++) p[l] = 0;
    drive_cycle(1'b0, p, 1'b1);
    for (int k = 0; k < CC; k++) begin
      for (int l = 0; l < NL; l++) p[l] = rnd_psum();
      drive_cycle(1'b1, p, 1'b1);
    end
    a_u = m_u;
    a_addr = m_addr;
    for (int k = 0; k < CC; k++)
      for (int l = 0; l < NL; l++) pb[k][l] = rnd_psum();
    for (int k = 0; k < CC - 1; k++) begin
      drive_cycle(1'b1, pb[k], 1'b0);
      n_checks++;
      if (got_rdy_u !== 1'b1 || got_rdy_s !== 1'b1) begin
        n_errors++; $display("FAIL b2b_early_rdy beat%0d got %b/%b want 1", k, got_rdy_u, got_rdy_s);
      end
    end
    for (int c = 0; c < 3; c++) begin
      drive_cycle(1'b1, pb[CC-1], 1'b0);
      n_checks++;
      if (got_rdy_u !== 1'b0 || got_rdy_s !== 1'b0) begin
        n_errors++; $display("FAIL b2b_stall_rdy cyc%0d got %b/%b want 0", c, got_rdy_u, got_rdy_s);
      end
      for (int l = 0; l < NL; l++) begin
        n_checks++;
        if (lane_u(l) !== a_u[l] || bus_u.data_out_vld !== 1'b1 || int'(bus_u.data_out_addr) !== a_addr) begin
          n_errors++; $display("FAIL b2b_hold_lane%0d got %0d addr %0d want %0d addr %0d", l, lane_u(l), bus_u.data_out_addr, a_u[l], a_addr);
        end
      end
    end
    drive_cycle(1'b1, pb[CC-1], 1'b1);
    n_checks++;
    if (got_rdy_u !== 1'b1 || bus_u.data_out_vld !== 1'b1) begin
      n_errors++; $display("FAIL b2b_reload got rdy %b vld %b want 1 1", got_rdy_u, bus_u.data_out_vld);
    end
    n_checks++;
    if (int'(bus_u.data_out_addr) !== (a_addr + 1) % NADDR) begin
      n_errors++; $display("FAIL b2b_addr got %0d want %0d", bus_u.data_out_addr, (a_addr + 1) % NADDR);
    end
    for (int l = 0; l < NL; l++) begin
      n_checks++;
      if (lane_u(l) !== m_u[l] || lane_s(l) !== m_s[l]) begin
        n_errors++; $display("FAIL b2b_lane%0d got %0d/%0d want %0d/%0d", l, lane_u(l), lane_s(l), m_u[l], m_s[l]);
      end
    end
  endtask

  task automatic test_random();
    lane_arr_t p;
    bit vld, drdy;
    for (int c = 0; c < 600; c++) begin
      for (int l = 0; l < NL; l++) p[l] = rnd_psum();
      vld  = ($urandom_range(0, 3) != 0);
      drdy = ($urandom_range(0, 2) != 0);
      drive_cycle(vld, p, drdy);
      n_checks++;
      if (got_rdy_u !== exp_rdy || got_rdy_s !== exp_rdy) begin
        n_errors++; $display("FAIL rnd_rdy cyc%0d got %b/%b want %b", c, got_rdy_u, got_rdy_s, exp_rdy);
      end
      n_checks++;
      if (bus_u.data_out_vld !== m_vld || bus_s.data_out_vld !== m_vld) begin
        n_errors++; $display("FAIL rnd_vld cyc%0d got %b/%b want %b", c, bus_u.data_out_vld, bus_s.data_out_vld, m_vld);
      end
      if (m_vld) begin
        n_checks++;
        if (int'(bus_u.data_out_addr) !== m_addr || int'(bus_s.data_out_addr) !== m_addr) begin
          n_errors++; $display("FAIL rnd_addr cyc%0d got %0d/%0d want %0d", c, bus_u.data_out_addr, bus_s.data_out_addr, m_addr);
        end
        for (int l = 0; l < NL; l++) begin
          n_checks++;
          if (lane_u(l) !== m_u[l] || lane_s(l) !== m_s[l]) begin
            n_errors++; $display("FAIL rnd_lane%0d cyc%0d got %0d/%0d want %0d/%0d", l, c, lane_u(l), lane_s(l), m_u[l], m_s[l]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_group();
    lane_arr_t p;
    do_reset();
    for (int l = 0; l < NL; l++) p[l] = 7;
    for (int k = 0; k < 3; k++) drive_cycle(1'b1, p, 1'b1);
    do_reset();
    n_checks++;
    if (bus_u.data_out_vld !== 1'b0 || bus_u.data_out_addr !== '0 || bus_u.data_out !== '0 || bus_u.nmc_cmOut_rdy !== 1'b1) begin
      n_errors++; $display("FAIL midrst_state got vld %b addr %0d data %h rdy %b want 0 0 0 1", bus_u.data_out_vld, bus_u.data_out_addr, bus_u.data_out, bus_u.nmc_cmOut_rdy);
    end
    for (int l = 0; l < NL; l++) p[l] = 2;
    for (int k = 0; k < CC; k++) drive_cycle(1'b1, p, 1'b1);
    for (int l = 0; l < NL; l++) begin
      n_checks++;
      if (lane_u(l) !== 510 || lane_s(l) !== -2 || bus_u.data_out_vld !== 1'b1) begin
        n_errors++; $display("FAIL midrst_lane%0d got %0d/%0d vld %b want 510/-2 vld 1", l, lane_u(l), lane_s(l), bus_u.data_out_vld);
      end
    end
    n_checks++;
    if (bus_u.data_out_addr !== AW'(0)) begin
      n_errors++; $display("FAIL midrst_addr got %0d want 0", bus_u.data_out_addr);
    end
  endtask

  task automatic test_addr_wrap();
    lane_arr_t p;
    do_reset();
    for (int g = 0; g <= NADDR; g++) begin
      for (int k = 0; k < CC; k++) begin
        for (int l = 0; l < NL; l++) p[l] = rnd_psum();
        drive_cycle(1'b1, p, 1'b1);
      end
      n_checks++;
      if (bus_u.data_out_vld !== 1'b1 || int'(bus_u.data_out_addr) !== g % NADDR) begin
        n_errors++; $display("FAIL wrap_addr grp%0d got %0d vld %b want %0d vld 1", g, bus_u.data_out_addr, bus_u.data_out_vld, g % NADDR);
      end
      n_checks++;
      if (lane_u(g % NL) !== m_u[g % NL]) begin
        n_errors++; $display("FAIL wrap_lane grp%0d got %0d want %0d", g, lane_u(g % NL), m_u[g % NL]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_ones();
    test_signed_planes();
    test_back_to_back();
    test_random();
    test_reset_mid_group();
    test_addr_wrap();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
